// File: rtl/bus16_arbiter_2m.sv
// Two-master round-robin arbiter and transaction sequencer for the 16-bit register bus.
// Optional read timeout is compiled in with `define BUS16_ARB_TIMEOUT_EN.
module bus16_arbiter_2m #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  i_Bus_Clk,
    input  logic                  i_Bus_Rst_L,

    input  logic                  i_Req0_Valid,
    input  logic                  i_Req0_Wr_Rd_n,
    input  logic [ADDR_WIDTH-1:0] i_Req0_Addr,
    input  logic [15:0]           i_Req0_Wr_Data,
    output logic                  o_Req0_Done,
    output logic                  o_Req0_Err,
    output logic [15:0]           o_Req0_Rd_Data,

    input  logic                  i_Req1_Valid,
    input  logic                  i_Req1_Wr_Rd_n,
    input  logic [ADDR_WIDTH-1:0] i_Req1_Addr,
    input  logic [15:0]           i_Req1_Wr_Data,
    output logic                  o_Req1_Done,
    output logic                  o_Req1_Err,
    output logic [15:0]           o_Req1_Rd_Data,

    output logic                  o_Bus_CS,
    output logic                  o_Bus_Wr_Rd_n,
    output logic [ADDR_WIDTH-1:0] o_Bus_Addr,
    output logic [15:0]           o_Bus_Wr_Data,
    input  logic [15:0]           i_Bus_Rd_Data,
    input  logic                  i_Bus_Rd_DV
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t                state_q, state_d;
    logic                  last_q, last_d;      // requester granted most recently
    logic                  gnt_q, gnt_d;        // requester owning the current transaction
    logic                  bus_cs_q, bus_cs_d;
    logic                  bus_wr_rd_n_q, bus_wr_rd_n_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [15:0]           bus_wr_data_q, bus_wr_data_d;
    logic                  done0_q, done0_d;
    logic                  done1_q, done1_d;
    logic                  err0_q, err0_d;
    logic                  err1_q, err1_d;
    logic [15:0]           rd_data0_q, rd_data0_d;
    logic [15:0]           rd_data1_q, rd_data1_d;
`ifdef BUS16_ARB_TIMEOUT_EN
    logic [7:0]            tmo_cnt_q, tmo_cnt_d;
    logic [7:0]            tmo_next;
`endif

    logic                  grant;
    logic                  xfer_done;
    logic                  xfer_err;
    logic [15:0]           xfer_data;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        gnt_d         = gnt_q;
        bus_cs_d      = 1'b0;
        bus_wr_rd_n_d = bus_wr_rd_n_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        err0_d        = 1'b0;
        err1_d        = 1'b0;
        rd_data0_d    = 16'h0000;
        rd_data1_d    = 16'h0000;
        grant         = 1'b0;
        xfer_done     = 1'b0;
        xfer_err      = 1'b0;
        xfer_data     = 16'h0000;
`ifdef BUS16_ARB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        tmo_next      = tmo_cnt_q + 8'd1;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_Req0_Valid || i_Req1_Valid) begin
                    // Under contention the pointer hands the bus to whoever did not have it last.
                    grant         = (i_Req0_Valid && i_Req1_Valid) ? ~last_q : i_Req1_Valid;
                    gnt_d         = grant;
                    last_d        = grant;
                    bus_cs_d      = 1'b1;
                    bus_wr_rd_n_d = grant ? i_Req1_Wr_Rd_n : i_Req0_Wr_Rd_n;
                    bus_addr_d    = grant ? i_Req1_Addr    : i_Req0_Addr;
                    bus_wr_data_d = grant ? i_Req1_Wr_Data : i_Req0_Wr_Data;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus_wr_rd_n_q) begin
                    xfer_done = 1'b1;
                    state_d   = S_DONE;
                end else begin
`ifdef BUS16_ARB_TIMEOUT_EN
                    tmo_cnt_d = 8'd0;
`endif
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_Bus_Rd_DV) begin
                    xfer_done = 1'b1;
                    xfer_data = i_Bus_Rd_Data;
                    state_d   = S_DONE;
                end
`ifdef BUS16_ARB_TIMEOUT_EN
                else begin
                    tmo_cnt_d = tmo_next;
                    if (tmo_next == 8'(TIMEOUT_CYCLES)) begin
                        xfer_done = 1'b1;
                        xfer_err  = 1'b1;
                        state_d   = S_DONE;
                    end
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Completion is steered only to the owner; the other requester sees zeros.
        if (xfer_done) begin
            if (gnt_q) begin
                done1_d    = 1'b1;
                err1_d     = xfer_err;
                rd_data1_d = xfer_data;
            end else begin
                done0_d    = 1'b1;
                err0_d     = xfer_err;
                rd_data0_d = xfer_data;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            state_q       <= S_IDLE;
            last_q        <= 1'b1;
            gnt_q         <= 1'b0;
            bus_cs_q      <= 1'b0;
            bus_wr_rd_n_q <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= 16'h0000;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            err0_q        <= 1'b0;
            err1_q        <= 1'b0;
            rd_data0_q    <= 16'h0000;
            rd_data1_q    <= 16'h0000;
`ifdef BUS16_ARB_TIMEOUT_EN
            tmo_cnt_q     <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            gnt_q         <= gnt_d;
            bus_cs_q      <= bus_cs_d;
            bus_wr_rd_n_q <= bus_wr_rd_n_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            err0_q        <= err0_d;
            err1_q        <= err1_d;
            rd_data0_q    <= rd_data0_d;
            rd_data1_q    <= rd_data1_d;
`ifdef BUS16_ARB_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    assign o_Bus_CS       = bus_cs_q;
    assign o_Bus_Wr_Rd_n  = bus_wr_rd_n_q;
    assign o_Bus_Addr     = bus_addr_q;
    assign o_Bus_Wr_Data  = bus_wr_data_q;
    assign o_Req0_Done    = done0_q;
    assign o_Req1_Done    = done1_q;
    assign o_Req0_Rd_Data = rd_data0_q;
    assign o_Req1_Rd_Data = rd_data1_q;
`ifdef BUS16_ARB_TIMEOUT_EN
    assign o_Req0_Err     = err0_q;
    assign o_Req1_Err     = err1_q;
`else
    assign o_Req0_Err     = 1'b0;
    assign o_Req1_Err     = 1'b0;
`endif

endmodule

// File: tb/tb_bus16_arbiter_2m.sv
// Directed bench for bus16_arbiter_2m: writes, reads, round-robin contention,
// read timeout (when BUS16_ARB_TIMEOUT_EN is defined), stray Rd_DV and mid-transaction reset.
module tb_bus16_arbiter_2m;

    logic        clk;
    logic        rst_n;
    logic        v0, wr0, v1, wr1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        done0, err0, done1, err1;
    logic [15:0] rdata0, rdata1;
    logic        bus_cs, bus_wr;
    logic [7:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_dv;

    int n_tests = 0;
    int n_fail  = 0;

    bus16_arbiter_2m #(
        .ADDR_WIDTH    (8),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .i_Bus_Clk     (clk),
        .i_Bus_Rst_L   (rst_n),
        .i_Req0_Valid  (v0),
        .i_Req0_Wr_Rd_n(wr0),
        .i_Req0_Addr   (addr0),
        .i_Req0_Wr_Data(wdata0),
        .o_Req0_Done   (done0),
        .o_Req0_Err    (err0),
        .o_Req0_Rd_Data(rdata0),
        .i_Req1_Valid  (v1),
        .i_Req1_Wr_Rd_n(wr1),
        .i_Req1_Addr   (addr1),
        .i_Req1_Wr_Data(wdata1),
        .o_Req1_Done   (done1),
        .o_Req1_Err    (err1),
        .o_Req1_Rd_Data(rdata1),
        .o_Bus_CS      (bus_cs),
        .o_Bus_Wr_Rd_n (bus_wr),
        .o_Bus_Addr    (bus_addr),
        .o_Bus_Wr_Data (bus_wdata),
        .i_Bus_Rd_Data (bus_rdata),
        .i_Bus_Rd_DV   (bus_dv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled mid-cycle on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n0, n1, grants;
        logic exp_owner, owner;

        rst_n = 1'b0;
        v0 = 1'b0; wr0 = 1'b0; addr0 = 8'h00; wdata0 = 16'h0000;
        v1 = 1'b0; wr1 = 1'b0; addr1 = 8'h00; wdata1 = 16'h0000;
        bus_rdata = 16'h0000; bus_dv = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cs", bus_cs, 0);
        check("rst_done0", done0, 0);
        check("rst_done1", done1, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_wr", bus_wr, 0);
        check("rst_err0", err0, 0);
        check("rst_rdata1", rdata1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Req0 write 0x03 <- 0xA5C3: CS at cycle 1, Done at cycle 2
        v0 = 1'b1; wr0 = 1'b1; addr0 = 8'h03; wdata0 = 16'hA5C3;
        tick();
        check("wr_cs", bus_cs, 1);
        check("wr_dir", bus_wr, 1);
        check("wr_addr", bus_addr, 8'h03);
        check("wr_data", bus_wdata, 16'hA5C3);
        check("wr_early_done", done0, 0);
        tick();
        check("wr_done0", done0, 1);
        check("wr_done1", done1, 0);
        check("wr_cs_low", bus_cs, 0);
        check("wr_err0", err0, 0);
        v0 = 1'b0;
        tick();
        check("wr_done_1cyc", done0, 0);
        check("hold_addr", bus_addr, 8'h03);
        check("hold_data", bus_wdata, 16'hA5C3);
        check("hold_cs", bus_cs, 0);

        // Req1 read 0x05, Rd_DV at cycle 2 -> Done at cycle 3
        v1 = 1'b1; wr1 = 1'b0; addr1 = 8'h05;
        tick();
        check("rd_cs", bus_cs, 1);
        check("rd_dir", bus_wr, 0);
        check("rd_addr", bus_addr, 8'h05);
        tick();
        check("rd_wait_done", done1, 0);
        bus_dv = 1'b1; bus_rdata = 16'h1234;
        tick();
        bus_dv = 1'b0; bus_rdata = 16'h0000;
        check("rd_done1", done1, 1);
        check("rd_data1", rdata1, 16'h1234);
        check("rd_err1", err1, 0);
        check("rd_done0", done0, 0);
        check("rd_data0_zero", rdata0, 0);
        v1 = 1'b0;
        tick();

        // Stray Rd_DV while idle must not reach anyone
        bus_dv = 1'b1; bus_rdata = 16'hDEAD;
        tick();
        bus_dv = 1'b0; bus_rdata = 16'h0000;
        check("stray_done0", done0, 0);
        check("stray_done1", done1, 0);
        check("stray_cs", bus_cs, 0);
        tick();
        check("stray_done0_b", done0, 0);

        // Req0 read 0x09 with Rd_DV at cycle 3 -> Done at cycle 4 with the later data
        v0 = 1'b1; wr0 = 1'b0; addr0 = 8'h09;
        tick();
        check("rd2_cs", bus_cs, 1);
        tick();
        check("rd2_wait", done0, 0);
        tick();
        check("rd2_wait_b", done0, 0);
        bus_dv = 1'b1; bus_rdata = 16'hBEEF;
        tick();
        bus_dv = 1'b0; bus_rdata = 16'h0000;
        check("rd2_done0", done0, 1);
        check("rd2_data0", rdata0, 16'hBEEF);
        check("rd2_err0", err0, 0);
        v0 = 1'b0;
        tick();

`ifdef BUS16_ARB_TIMEOUT_EN
        // Read with no Rd_DV: 4 WAIT cycles (2..5), Done+Err at cycle 6
        v1 = 1'b1; wr1 = 1'b0; addr1 = 8'h0A;
        tick();
        check("tmo_cs", bus_cs, 1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("tmo_early", done1, 0);
        end
        tick();
        check("tmo_done1", done1, 1);
        check("tmo_err1", err1, 1);
        check("tmo_data1", rdata1, 0);
        v1 = 1'b0;
        tick();
        bus_dv = 1'b1; bus_rdata = 16'h5555;
        tick();
        bus_dv = 1'b0; bus_rdata = 16'h0000;
        check("tmo_stray_done1", done1, 0);
        check("tmo_stray_done0", done0, 0);
        tick();
        check("tmo_stray_done1_b", done1, 0);

        // Rd_DV on the cycle the counter hits the limit: data wins
        v1 = 1'b1; wr1 = 1'b0; addr1 = 8'h0B;
        tick();
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("edge_early", done1, 0);
        end
        bus_dv = 1'b1; bus_rdata = 16'h0F0F;
        tick();
        bus_dv = 1'b0; bus_rdata = 16'h0000;
        check("edge_done1", done1, 1);
        check("edge_err1", err1, 0);
        check("edge_data1", rdata1, 16'h0F0F);
        v1 = 1'b0;
        tick();
`else
        // Without timeout a read waits indefinitely; Err never asserts
        v1 = 1'b1; wr1 = 1'b0; addr1 = 8'h0A;
        tick();
        check("notmo_cs", bus_cs, 1);
        for (int c = 2; c <= 10; c++) begin
            tick();
            check("notmo_early", done1, 0);
        end
        bus_dv = 1'b1; bus_rdata = 16'h6789;
        tick();
        bus_dv = 1'b0; bus_rdata = 16'h0000;
        check("notmo_done1", done1, 1);
        check("notmo_err1", err1, 0);
        check("notmo_data1", rdata1, 16'h6789);
        v1 = 1'b0;
        tick();
`endif

        // Contention from reset: both hold Valid for 4 writes each -> 0,1,0,1,...
        apply_reset();
        n0 = 0; n1 = 0; grants = 0; exp_owner = 1'b0;
        v0 = 1'b1; wr0 = 1'b1; addr0 = 8'h10; wdata0 = 16'hA000;
        v1 = 1'b1; wr1 = 1'b1; addr1 = 8'h20; wdata1 = 16'hB000;
        for (int cyc = 0; cyc < 60 && (n0 < 4 || n1 < 4); cyc++) begin
            tick();
            if (bus_cs) begin
                owner = bus_addr[5];
                check("rr_owner", owner, exp_owner);
                check("rr_data", bus_wdata, owner ? 16'hB000 + 16'(n1) : 16'hA000 + 16'(n0));
                exp_owner = ~exp_owner;
                grants++;
            end
            if (done0 && done1) check("rr_both_done", 1, 0);
            if (done0) begin
                n0++;
                if (n0 == 4) v0 = 1'b0;
                else begin addr0 = 8'h10 + 8'(n0); wdata0 = 16'hA000 + 16'(n0); end
            end
            if (done1) begin
                n1++;
                if (n1 == 4) v1 = 1'b0;
                else begin addr1 = 8'h20 + 8'(n1); wdata1 = 16'hB000 + 16'(n1); end
            end
        end
        check("rr_grants", grants, 8);
        check("rr_n0", n0, 4);
        check("rr_n1", n1, 4);
        tick();

        // Reset during WAIT of a Req0 read: outputs clear at once, no Done
        v0 = 1'b1; wr0 = 1'b0; addr0 = 8'h7E;
        tick();
        check("rst_wait_cs", bus_cs, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_addr", bus_addr, 0);
        check("arst_cs", bus_cs, 0);
        check("arst_done0", done0, 0);
        v0 = 1'b0;
        tick();
        check("arst_no_done", done0, 0);
        check("arst_wdata", bus_wdata, 0);
        rst_n = 1'b1;
        v0 = 1'b1; wr0 = 1'b1; addr0 = 8'h30; wdata0 = 16'h3030;
        v1 = 1'b1; wr1 = 1'b1; addr1 = 8'h40; wdata1 = 16'h4040;
        tick();
        check("post_rst_cs", bus_cs, 1);
        check("post_rst_owner", bus_addr, 8'h30);
        tick();
        check("post_rst_done0", done0, 1);
        check("post_rst_done1", done1, 0);
        v0 = 1'b0; v1 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
